dmem_store_buffer: RTL

Write-back store buffer between the single-cycle core's data port and the single-port `dmem`. Core stores retire immediately into a small FIFO; the FIFO drains to memory in cycles when the core is not issuing a load. Loads are served from the newest matching buffered store, or from memory. A fence request stalls the core until the buffer is empty.

---
 rtl/dmem_store_buffer_if.sv | 39 +++
 rtl/dmem_store_buffer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer_if.sv
// ---------------------------------------------------------------------------
// dmem_store_buffer_if
// Bundles the core-side data port and the dmem-side port of the store buffer.
//   cpu_we / cpu_re      : store / load strobes from the core
//   cpu_adr / cpu_wd     : byte address and store data from the core
//   cpu_rd               : load data returned to the core
//   fence_req / stall    : fence request in, pipeline stall out
//   mem_we/mem_adr/mem_wd: write port towards dmem
//   mem_rd               : combinational read data from dmem
// Modports:
//   slave  - the store buffer itself
//   master - the surrounding core + dmem environment
// ---------------------------------------------------------------------------
interface dmem_store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_we;
    logic          cpu_re;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wd;
    logic [DW-1:0] cpu_rd;
    logic          fence_req;
    logic          stall;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  cpu_we, cpu_re, cpu_adr, cpu_wd, fence_req, mem_rd,
        output cpu_rd, stall, mem_we, mem_adr, mem_wd
    );

    modport master (
        output cpu_we, cpu_re, cpu_adr, cpu_wd, fence_req, mem_rd,
        input  cpu_rd, stall, mem_we, mem_adr, mem_wd
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// ---------------------------------------------------------------------------
// dmem_store_buffer
// Write-back store buffer between the core data port and a single-port dmem.
// Stores retire into a circular FIFO and drain to dmem whenever the core is
// not using the port for a load. A fence stalls the core until the FIFO is
// empty.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - dmem_store_buffer_if.slave (core side + dmem side)
// Configuration macro:
//   SB_FWD_EN - defined: loads are forwarded from the newest matching entry.
//               undefined: no forwarding; a load that hits a buffered store
//               stalls until the matching entries have drained.
// ---------------------------------------------------------------------------
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input logic                 clk,
    input logic                 reset,
    dmem_store_buffer_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-3:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] hd_q, hd_d;
    logic [PW-1:0] tl_q, tl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          empty;
    logic          full;
    logic          hit;
    logic          stallInt;
    logic          drain;
    logic          push;
    logic [PW-1:0] idx;
`ifdef SB_FWD_EN
    logic [DW-1:0] fwdData;
`endif

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

    // Walk valid entries oldest to newest so the last hit is the newest store.
    always_comb begin
        hit = 1'b0;
        idx = '0;
`ifdef SB_FWD_EN
        fwdData = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = hd_q + PW'(k);
            if ((CW'(k) < cnt_q) && (addr_q[idx] == bus.cpu_adr[AW-1:2])) begin
                hit = 1'b1;
`ifdef SB_FWD_EN
                fwdData = data_q[idx];
`endif
            end
        end
    end

`ifdef SB_FWD_EN
    assign stallInt   = bus.fence_req && !empty;
    assign bus.cpu_rd = hit ? fwdData : bus.mem_rd;
`else
    // Without forwarding a load that hits the buffer must wait for dmem.
    assign stallInt   = !empty && (bus.fence_req || (bus.cpu_re && hit));
    assign bus.cpu_rd = bus.mem_rd;
`endif

    // The port belongs to the buffer unless an unstalled load needs it.
    assign drain = !empty && (!bus.cpu_re || stallInt);
    // A store at full always coincides with a drain, so it never overflows.
    assign push  = bus.cpu_we && !stallInt && (!full || drain);

    assign bus.stall   = stallInt;
    assign bus.mem_we  = drain;
    assign bus.mem_adr = drain ? {addr_q[hd_q], 2'b00} : bus.cpu_adr;
    assign bus.mem_wd  = drain ? data_q[hd_q] : '0;

    // Pointers wrap naturally modulo DEPTH; cnt distinguishes full from empty.
    always_comb begin
        hd_d  = drain ? hd_q + PW'(1) : hd_q;
        tl_d  = push  ? tl_q + PW'(1) : tl_q;
        cnt_d = cnt_q;
        if (push && !drain) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && drain) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hd_q  <= '0;
            tl_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            cnt_q <= cnt_d;
            if (push) begin
                addr_q[tl_q] <= bus.cpu_adr[AW-1:2];
                data_q[tl_q] <= bus.cpu_wd;
            end
        end
    end

`ifndef SYNTHESIS
    // A single-cycle core can never load and store in the same instruction.
    noLoadAndStore: assert property (@(posedge clk) disable iff (!reset)
        !(bus.cpu_we && bus.cpu_re));
`endif
endmodule
